keypad_scan_encoder: RTL

Upstream stage of the door lock FSM. Scans a 4x4 active-low matrix keypad, synchronises and debounces the row returns, and encodes each accepted press into a 4-bit code on `keypad`. The code is asserted for exactly one clock cycle per physical press, and `keypad` is 0 at all other times, so the lock FSM captures each digit exactly once.

---
 rtl/keypad_scan_encoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 active-low matrix keypad. The row returns
// are synchronised and debounced, and each accepted press becomes a
// single-cycle 4-bit code on keypad, or a clear pulse for '*'.
// Optional key-click beep output: define KEYPAD_BEEP_EN.
module keypad_scan_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int BEEP_CYC     = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keypad,
  output logic       clear,
  output logic       key_held,
  output logic       beep
);

  localparam int MAXA = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int MAXP = (MAXA > BEEP_CYC) ? MAXA : BEEP_CYC;
  localparam int CW   = (MAXP > 2) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {SCAN, DEBOUNCE, FIRE, HELD, RELEASE} state_t;
  typedef struct packed {
    logic [1:0] ridx;
    logic [3:0] rpat;
  } press_t;

  state_t        state;
  logic [CW-1:0] cnt;
  press_t        cap;
  logic [3:0]    row_s1, rs;
  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    ridx_now, cidx;
  logic [3:0]    key_code;
  logic          is_star;
  logic [3:0]    col_nxt;

  // two-flop synchroniser on the asynchronous row returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      row_s1 <= row;
      rs     <= row_s1;
    end
  end

  // single-low-row detection; two or more lows are treated as ghosting
  always_comb begin
    low      = ~rs;
    one_low  = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    ridx_now = 2'd0;
    if      (low[0]) ridx_now = 2'd0;
    else if (low[1]) ridx_now = 2'd1;
    else if (low[2]) ridx_now = 2'd2;
    else if (low[3]) ridx_now = 2'd3;
  end

  // column index of the driven column and next column in rotation
  always_comb begin
    col_nxt = {col[2:0], col[3]};
    case (col)
      4'b1110: cidx = 2'd0;
      4'b1101: cidx = 2'd1;
      4'b1011: cidx = 2'd2;
      default: cidx = 2'd3;
    endcase
  end

  // row-major key map; '*' has no code and drives clear instead
  always_comb begin
    key_code = 4'h0;
    is_star  = 1'b0;
    case ({cap.ridx, cidx})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = 4'hB;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = 4'hC;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = 4'hD;
      4'b11_00: is_star  = 1'b1;
      4'b11_01: key_code = 4'hA;
      4'b11_10: key_code = 4'hF;
      default:  key_code = 4'hE;
    endcase
  end

  // scan / debounce / fire / hold / release sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SCAN;
      cnt      <= '0;
      cap      <= '0;
      col      <= 4'b1110;
      keypad   <= 4'h0;
      clear    <= 1'b0;
      key_held <= 1'b0;
    end else begin
      keypad <= 4'h0;
      clear  <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            if (one_low) begin
              cap.ridx <= ridx_now;
              cap.rpat <= rs;
              state    <= DEBOUNCE;
            end else begin
              col <= col_nxt;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (rs != cap.rpat) begin
            state <= SCAN;
            cnt   <= '0;
            col   <= col_nxt;
          end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            state    <= FIRE;
            cnt      <= '0;
            key_held <= 1'b1;
            if (is_star) clear  <= 1'b1;
            else         keypad <= key_code;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIRE: state <= HELD;
        HELD: begin
          if (rs == 4'hF) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (rs != 4'hF) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            state    <= SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            col      <= col_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_BEEP_EN
  localparam int BW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
  logic [BW-1:0] bcnt;

  // key-click pulse starting the cycle after FIRE; a new FIRE restarts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beep <= 1'b0;
      bcnt <= '0;
    end else if (state == FIRE) begin
      beep <= 1'b1;
      bcnt <= '0;
    end else if (beep) begin
      if (bcnt == BW'(BEEP_CYC - 1)) beep <= 1'b0;
      else                           bcnt <= bcnt + BW'(1);
    end
  end
`else
  assign beep = 1'b0;
`endif

endmodule
